whack_game_ctrl: RTL and testbench
==================================

Name: whack_game_ctrl

Overview:
- Game sequencer for the whack-a-mole datapath. It runs the round FSM and the mole and gap timers, and picks mole positions with an LFSR.
- It judges each key press as a hit or a miss, keeps the score, and writes the final score to the 32-entry score RAM.
- It drives the datapath state code, score and RAM write strobe/address; the datapath follows this block.

Parameters:
- TICKS_PER_MOLE, 50000000, clock cycles a mole stays visible before timing out (>=2).
- GAP_TICKS, 12500000, blank cycles between moles (>=1).
- NUM_ROUNDS, 16, moles per game (1..31).

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  start request, level; sampled in IDLE and DONE only.
- keys  in  4  player buttons, already synchronised, active-high level.
- state  out  3  FSM code to datapath: IDLE=000, START=001, SHOW=010, GAP=011, SAVE=110, DONE=111.
- mole  out  4  one-hot active mole; 0 when no mole is shown.
- score  out  8  current game score.
- round  out  5  rounds completed in the current game.
- hit  out  1  one-cycle pulse on a hit.
- miss  out  1  one-cycle pulse on a wrong key or a timeout.
- wren  out  1  score RAM write strobe.
- address  out  5  score RAM address.
- wdata  out  8  score RAM write data.
- game_over  out  1  high while in DONE.

Behaviour:
- Reset (async): every output 0, state=IDLE; tick counter 0; key history 0; LFSR=8'h01; previous mole index 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It shifts every cycle in every state; Reset is its only seed.
- Key edges: kedge = keys & ~keys_q, with keys_q registered every cycle. Only rising edges count. Held keys never re-trigger.
- IDLE: start=1 -> START next cycle.
- START (1 cycle): score, round and tick counter cleared.
  - Mole index chosen: idx = lfsr[1:0]; if idx equals the previous mole index, use idx+1 mod 4.
  - -> SHOW with mole=onehot(idx). Latency: start high in cycle N gives mole valid in cycle N+2.
- SHOW: tick counter increments each cycle. Priority, evaluated each cycle:
  - 1. kedge & mole != 0 -> hit: hit=1, score+1 saturating at 255, mole=0, -> GAP. Hit wins over a same-cycle wrong key or timeout.
  - 2. kedge != 0 (wrong key) -> miss=1; mole stays; timer continues; state unchanged.
  - 3. tick counter == TICKS_PER_MOLE-1 -> miss=1, mole=0, -> GAP.
  - Only one miss pulse per cycle, even if several wrong keys rise together.
- GAP: mole=0; key edges ignored (no hit/miss). Tick counter reset on entry, and the GAP lasts exactly GAP_TICKS cycles. On exit, round increments:
  - round (after increment) == NUM_ROUNDS -> SAVE.
  - otherwise a new idx is picked by the same no-repeat rule -> SHOW, counter reset, previous index updated.
- SAVE (1 cycle): wren=1, wdata=score, address = current slot -> DONE.
  - address increments by 1, mod 32, on the cycle after SAVE. Address 31 wraps to 0.
- DONE: game_over=1; score, round and address held. start=1 -> START.
- start is ignored in START, SHOW, GAP and SAVE. A mid-game start has no effect.
- Reset at any point, including during SAVE: immediate return to reset values, with no partial write. wren deasserts asynchronously.
- Score is never decremented; misses only pulse miss.
- Widths: tick counter is 26 bits (covers 50M). round is 5 bits; NUM_ROUNDS<=31 guarantees no overflow.

Test Plan:
- Params TICKS_PER_MOLE=10, GAP_TICKS=4, NUM_ROUNDS=3. Start pulse, no keys -> 3 timeouts, each a miss pulse 10 cycles after mole asserts. Then SAVE with wren=1, wdata=0, address=0. Then DONE, game_over=1, address=1.
- Press the correct key 3 cycles into each SHOW -> hit pulse each round; score 1,2,3; mole clears the same cycle as hit. SAVE writes wdata=3.
- Wrong key edge, then correct key 2 cycles later -> one miss pulse, then a hit. Mole is unchanged between them; score +1.
- Correct and wrong key rise in the same cycle that the timer expires -> hit=1, miss=0, score +1.
- Hold the correct key across a mole change, and press keys during GAP -> no hit/miss from the held key or the GAP presses. Consecutive moles are never the same index over 100 games.
- Assert Reset during SHOW and during SAVE -> all outputs 0 immediately with no wren pulse. Also play 33 games and check address wraps 31 -> 0.

Source files
------------

// File: rtl/whack_game_ctrl.sv
// rtl/whack_game_ctrl.sv - whack-a-mole round sequencer: FSM, mole/gap timers, LFSR mole pick, scoring, score RAM write
module whack_game_ctrl #(
    parameter int TICKS_PER_MOLE = 50000000,
    parameter int GAP_TICKS      = 12500000,
    parameter int NUM_ROUNDS     = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [3:0] keys,
    output logic [2:0] state,
    output logic [3:0] mole,
    output logic [7:0] score,
    output logic [4:0] round,
    output logic       hit,
    output logic       miss,
    output logic       wren,
    output logic [4:0] address,
    output logic [7:0] wdata,
    output logic       game_over
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_START = 3'b001;
    localparam logic [2:0] S_SHOW  = 3'b010;
    localparam logic [2:0] S_GAP   = 3'b011;
    localparam logic [2:0] S_SAVE  = 3'b110;
    localparam logic [2:0] S_DONE  = 3'b111;

    localparam logic [25:0] MOLE_LAST  = 26'(TICKS_PER_MOLE - 1);
    localparam logic [25:0] GAP_LAST   = 26'(GAP_TICKS - 1);
    localparam logic [4:0]  ROUNDS_END = 5'(NUM_ROUNDS);

    logic [2:0]  state_q, state_d;
    logic [25:0] tick_q, tick_d;
    logic [3:0]  mole_q, mole_d;
    logic [7:0]  score_q, score_d;
    logic [4:0]  round_q, round_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        wren_q, wren_d;
    logic [4:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        over_q, over_d;
    logic [1:0]  prev_idx_q, prev_idx_d;
    logic [7:0]  lfsr_q;
    logic [3:0]  keys_q;

    logic [3:0]  kedge;
    logic [1:0]  next_idx;
    logic [4:0]  round_inc;

    // Only rising edges of the synchronised keys count as presses.
    assign kedge     = keys & ~keys_q;
    // Never show the same hole twice in a row: bump a repeated pick by one.
    assign next_idx  = (lfsr_q[1:0] == prev_idx_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];
    assign round_inc = round_q + 5'd1;

    // Key history and free-running LFSR (taps 8,6,5,4), seeded only by reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            keys_q <= 4'd0;
            lfsr_q <= 8'h01;
        end else begin
            keys_q <= keys;
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Round FSM: next-state, timers, hit/miss judgement and score bookkeeping.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        mole_d     = mole_q;
        score_d    = score_q;
        round_d    = round_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        over_d     = 1'b0;
        prev_idx_d = prev_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    score_d = 8'd0;
                    round_d = 5'd0;
                    tick_d  = 26'd0;
                end
            end
            S_START: begin
                mole_d     = 4'b0001 << next_idx;
                prev_idx_d = next_idx;
                tick_d     = 26'd0;
                state_d    = S_SHOW;
            end
            S_SHOW: begin
                tick_d = tick_q + 26'd1;
                if ((kedge & mole_q) != 4'd0) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    mole_d  = 4'd0;
                    tick_d  = 26'd0;
                    state_d = S_GAP;
                end else if (kedge != 4'd0) begin
                    miss_d = 1'b1;
                end else if (tick_q >= MOLE_LAST) begin
                    // >= so a wrong key on the final tick delays the timeout by one cycle
                    miss_d  = 1'b1;
                    mole_d  = 4'd0;
                    tick_d  = 26'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                mole_d = 4'd0;
                if (tick_q >= GAP_LAST) begin
                    round_d = round_inc;
                    tick_d  = 26'd0;
                    if (round_inc == ROUNDS_END) begin
                        state_d = S_SAVE;
                        wren_d  = 1'b1;
                        wdata_d = score_q;
                    end else begin
                        mole_d     = 4'b0001 << next_idx;
                        prev_idx_d = next_idx;
                        state_d    = S_SHOW;
                    end
                end else begin
                    tick_d = tick_q + 26'd1;
                end
            end
            S_SAVE: begin
                addr_d  = addr_q + 5'd1;
                over_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                over_d = 1'b1;
                if (start) begin
                    over_d  = 1'b0;
                    score_d = 8'd0;
                    round_d = 5'd0;
                    tick_d  = 26'd0;
                    state_d = S_START;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and output registers; reset clears everything, including a write in flight.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            tick_q     <= 26'd0;
            mole_q     <= 4'd0;
            score_q    <= 8'd0;
            round_q    <= 5'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= 5'd0;
            wdata_q    <= 8'd0;
            over_q     <= 1'b0;
            prev_idx_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            mole_q     <= mole_d;
            score_q    <= score_d;
            round_q    <= round_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            over_q     <= over_d;
            prev_idx_q <= prev_idx_d;
        end
    end

    assign state     = state_q;
    assign mole      = mole_q;
    assign score     = score_q;
    assign round     = round_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign wren      = wren_q;
    assign address   = addr_q;
    assign wdata     = wdata_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb/tb_whack_game_ctrl.sv - bench for whack_game_ctrl: cycle model, directed games, random games
module tb_whack_game_ctrl;

    localparam int TPM   = 10;
    localparam int GAPT  = 4;
    localparam int NROUN = 3;

    logic       clk;
    logic       Reset;
    logic       start;
    logic [3:0] keys;
    logic [2:0] state;
    logic [3:0] mole;
    logic [7:0] score;
    logic [4:0] round;
    logic       hit;
    logic       miss;
    logic       wren;
    logic [4:0] address;
    logic [7:0] wdata;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    whack_game_ctrl #(
        .TICKS_PER_MOLE(TPM),
        .GAP_TICKS(GAPT),
        .NUM_ROUNDS(NROUN)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .start(start),
        .keys(keys),
        .state(state),
        .mole(mole),
        .score(score),
        .round(round),
        .hit(hit),
        .miss(miss),
        .wren(wren),
        .address(address),
        .wdata(wdata),
        .game_over(game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [2:0] m_state;
    int         m_idx;
    int         m_prev;
    int         m_left;
    logic [7:0] m_score;
    logic [4:0] m_round;
    bit         m_hit, m_miss, m_wren, m_over;
    logic [4:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_lfsr;
    logic [3:0] m_kprev;

    function automatic int pick_idx(input logic [7:0] l, input int prev);
        int i;
        i = int'(l % 8'd4);
        if (i == prev) i = (i + 1) % 4;
        return i;
    endfunction

    function automatic logic [3:0] exp_mole();
        if (m_idx < 0) return 4'd0;
        return 4'(1 << m_idx);
    endfunction

    task automatic model_reset();
        m_state = 3'b000; m_idx = -1; m_prev = 0; m_left = 0;
        m_score = 0; m_round = 0; m_hit = 0; m_miss = 0; m_wren = 0; m_over = 0;
        m_addr = 0; m_wdata = 0; m_lfsr = 8'h01; m_kprev = 0;
    endtask

    task automatic model_step();
        logic [3:0] kedge;
        kedge = keys & ~m_kprev;
        m_hit = 0; m_miss = 0; m_wren = 0;
        case (m_state)
            3'b000: if (start) begin m_state = 3'b001; m_score = 0; m_round = 0; end
            3'b001: begin
                m_idx = pick_idx(m_lfsr, m_prev); m_prev = m_idx; m_left = TPM; m_state = 3'b010;
            end
            3'b010: begin
                if (kedge[m_idx]) begin
                    m_hit = 1;
                    if (m_score != 8'd255) m_score = m_score + 1;
                    m_idx = -1; m_state = 3'b011; m_left = GAPT;
                end else begin
                    if (kedge != 0) m_miss = 1;
                    else if (m_left <= 1) begin
                        m_miss = 1; m_idx = -1; m_state = 3'b011; m_left = GAPT;
                    end
                    if (m_state == 3'b010) m_left = m_left - 1;
                end
            end
            3'b011: begin
                if (m_left <= 1) begin
                    m_round = m_round + 1;
                    if (int'(m_round) == NROUN) begin
                        m_state = 3'b110; m_wren = 1; m_wdata = m_score;
                    end else begin
                        m_idx = pick_idx(m_lfsr, m_prev); m_prev = m_idx; m_left = TPM; m_state = 3'b010;
                    end
                end else m_left = m_left - 1;
            end
            3'b110: begin m_state = 3'b111; m_addr = m_addr + 1; m_over = 1; end
            3'b111: if (start) begin
                m_state = 3'b001; m_over = 0; m_score = 0; m_round = 0;
            end
            default: m_state = 3'b000;
        endcase
        m_lfsr  = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_kprev = keys;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Every-cycle comparison against the model, plus the no-repeat mole property.
    logic [3:0] last_mole;
    logic [3:0] dut_mole_prev;
    initial begin
        last_mole = 4'b0001;
        dut_mole_prev = 4'd0;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (Reset) begin
                    model_reset();
                    last_mole = 4'b0001;
                end
                chk("state", state, m_state);
                chk("mole", mole, exp_mole());
                chk("score", score, m_score);
                chk("round", round, m_round);
                chk("hit", hit, m_hit);
                chk("miss", miss, m_miss);
                chk("wren", wren, m_wren);
                chk("address", address, m_addr);
                chk("wdata", wdata, m_wdata);
                chk("game_over", game_over, m_over);
                if (!Reset && mole != 4'd0 && dut_mole_prev == 4'd0) begin
                    checks++;
                    if (mole == last_mole) begin
                        errors++;
                        $display("FAIL no_repeat: mole %0h repeated previous %0h", mole, last_mole);
                    end
                    last_mole = mole;
                end
                dut_mole_prev = mole;
                if (!Reset) model_step();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mole();
        int n;
        n = 0;
        while (mole == 4'd0 && n < 60) begin cyc(); n++; end
        if (mole == 4'd0) bound_fail("wait_mole");
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n;
        n = 0;
        while (state != s && n < 200) begin cyc(); n++; end
        if (state != s) bound_fail(name);
    endtask

    task automatic wait_wren();
        int n;
        n = 0;
        while (!wren && n < 200) begin cyc(); n++; end
        if (!wren) bound_fail("wait_wren");
    endtask

    function automatic logic [63:0] all_outs();
        return {27'd0, state, mole, score, round, hit, miss, wren, address, wdata, game_over};
    endfunction

    function automatic logic [3:0] rot(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    logic [3:0] saved;
    logic [7:0] sc;
    int         n;
    int         wraps;

    initial begin
        Reset = 1'b0; start = 1'b0; keys = 4'd0;
        #2 Reset = 1'b1;
        #1 cmp_en = 1'b1;
        chk("reset_outputs", all_outs(), 64'd0);
        cyc(); cyc();

        // Game 1: no keys, three timeouts.
        Reset = 1'b0; start = 1'b1;
        cyc();
        chk("start_state", state, 3'b001);
        chk("start_no_mole", mole, 4'd0);
        start = 1'b0;
        cyc();
        chk("first_mole", mole, 4'b0100);
        chk("show_state", state, 3'b010);
        for (int r = 0; r < NROUN; r++) begin
            if (r > 0) wait_mole();
            n = 0;
            do begin cyc(); n++; end while (!miss && n < 30);
            chk("timeout_latency", n, 10);
            chk("timeout_mole_clear", mole, 4'd0);
            chk("timeout_gap_state", state, 3'b011);
        end
        wait_wren();
        chk("save_state", state, 3'b110);
        chk("save_wdata_0", wdata, 8'd0);
        chk("save_addr_0", address, 5'd0);
        chk("round_at_save", round, 5'd3);
        cyc();
        chk("done_state", state, 3'b111);
        chk("done_over", game_over, 1'b1);
        chk("done_addr_1", address, 5'd1);

        // Game 2: correct key three cycles into every SHOW.
        start = 1'b1; cyc(); start = 1'b0;
        for (int r = 0; r < NROUN; r++) begin
            wait_mole();
            saved = mole;
            repeat (3) cyc();
            keys = saved;
            cyc();
            chk("hit_pulse", hit, 1'b1);
            chk("hit_mole_clear", mole, 4'd0);
            chk("hit_score", score, 8'(r + 1));
            keys = 4'd0;
        end
        wait_wren();
        chk("save_wdata_3", wdata, 8'd3);
        wait_state(3'b111, "wait_done2");

        // Game 3: wrong key then correct key; then hit colliding with timeout.
        start = 1'b1; cyc(); start = 1'b0;
        wait_mole();
        saved = mole; sc = score;
        cyc();
        keys = rot(saved);
        cyc();
        chk("wrong_miss", miss, 1'b1);
        chk("wrong_no_hit", hit, 1'b0);
        chk("wrong_mole_kept", mole, saved);
        keys = 4'd0;
        cyc();
        chk("miss_single_pulse", miss, 1'b0);
        chk("mole_still_kept", mole, saved);
        keys = saved;
        cyc();
        chk("late_hit", hit, 1'b1);
        chk("late_hit_score", score, 8'(sc + 1));
        keys = 4'd0;
        wait_mole();
        saved = mole; sc = score;
        repeat (9) cyc();
        keys = saved | rot(saved);
        cyc();
        chk("collide_hit", hit, 1'b1);
        chk("collide_no_miss", miss, 1'b0);
        chk("collide_mole_clear", mole, 4'd0);
        chk("collide_score", score, 8'(sc + 1));
        keys = 4'd0;
        wait_state(3'b111, "wait_done3");

        // Game 4: held key across a mole change, presses during GAP.
        start = 1'b1; cyc(); start = 1'b0;
        wait_mole();
        saved = mole;
        cyc();
        keys = saved;
        cyc();
        chk("held_hit", hit, 1'b1);
        keys = 4'hF; cyc(); chk("gap_quiet", {hit, miss}, 2'b00);
        keys = saved; cyc(); chk("gap_quiet", {hit, miss}, 2'b00);
        keys = 4'hF; cyc(); chk("gap_quiet", {hit, miss}, 2'b00);
        keys = saved;
        repeat (4) begin cyc(); chk("held_quiet", {hit, miss}, 2'b00); end
        chk("new_mole_shown", (mole != 4'd0 && mole != saved), 1'b1);
        keys = 4'd0;
        wait_state(3'b111, "wait_done4");

        // Reset during SHOW.
        start = 1'b1; cyc(); start = 1'b0;
        wait_mole();
        cyc(); cyc();
        Reset = 1'b1; #1;
        chk("reset_in_show", all_outs(), 64'd0);
        cyc();
        chk("reset_in_show_hold", all_outs(), 64'd0);
        Reset = 1'b0;

        // Reset during SAVE: write strobe must drop at once.
        start = 1'b1; cyc(); start = 1'b0;
        wait_wren();
        Reset = 1'b1; #1;
        chk("reset_in_save", all_outs(), 64'd0);
        cyc();
        chk("reset_in_save_hold", all_outs(), 64'd0);
        Reset = 1'b0;
        cyc();
        chk("no_wren_after_reset", wren, 1'b0);

        // 100 randomized games; address walks and wraps 31 -> 0.
        wraps = 0;
        for (int g = 0; g < 100; g++) begin
            logic [4:0] a;
            bit done;
            start = 1'b1; cyc(); start = 1'b0;
            n = 0; done = 0; a = 5'd0;
            while (!done && n < 400) begin
                case ($urandom_range(0, 7))
                    0: keys = exp_mole();
                    1: keys = 4'($urandom_range(0, 15));
                    2: keys = keys;
                    default: keys = 4'd0;
                endcase
                start = ($urandom_range(0, 15) == 0);
                cyc(); n++;
                if (wren) a = address;
                if (state == 3'b111) done = 1;
            end
            if (!done) bound_fail("random_game");
            else begin
                chk("addr_increment", address, 5'(a + 5'd1));
                if (a == 5'd31) wraps++;
            end
            start = 1'b0; keys = 4'd0;
        end
        chk("wrap_count", wraps, 3);
        chk("final_address", address, 5'd4);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
